pipeline_arbiter: RTL and testbench

PIPELINE_ARBITER -- requirements
Module: pipeline_arbiter

---
 rtl/pipeline_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_pipeline_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_arbiter.sv
// Four-requester round-robin front end for a shared in-order pipeline, with tag FIFO response routing.
// Optional statistics outputs are enabled by defining PIPE_ARB_STATS_EN.

module pipeline_arbiter #(
  parameter int DATA_W    = 16,
  parameter int TAG_DEPTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4*DATA_W-1:0]   req_data,
  input  logic [3:0]            req_valid,
  output logic [3:0]            req_ready,
  output logic [DATA_W-1:0]     data,
  output logic                  data_valid,
  input  logic                  data_ready,
  input  logic [DATA_W-1:0]     result,
  input  logic                  result_valid,
  output logic                  result_ready,
  output logic [DATA_W-1:0]     rsp_result,
  output logic [3:0]            rsp_valid,
  input  logic [3:0]            rsp_ready,
  output logic                  busy,
  output logic                  err_orphan
`ifdef PIPE_ARB_STATS_EN
  ,
  output logic [4*16-1:0]       stat_grants,
  output logic [15:0]           stat_stall
`endif
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  function automatic logic [3:0] id_onehot(input logic [1:0] id);
    case (id)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0010;
      2'd2:    return 4'b0100;
      2'd3:    return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  logic [1:0]       last_grant_r;
  logic             lock_r;
  logic [1:0]       lock_id_r;
  logic [1:0]       tag_mem_r [TAG_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             err_orphan_r;

  logic [1:0]       cand_s;
  logic [1:0]       rr_id_s;
  logic             rr_found_s;
  logic             lock_hold_s;
  logic [1:0]       grant_id_s;
  logic             any_valid_s;
  logic             tag_full_s;
  logic             tag_empty_s;
  logic [1:0]       head_id_s;
  logic             push_s;
  logic             pop_s;

  // Round-robin search starting one past the last accepted requester.
  always_comb begin
    cand_s     = last_grant_r;
    rr_id_s    = last_grant_r;
    rr_found_s = 1'b0;
    for (int unsigned k = 32'd0; k < 32'd4; k++) begin
      cand_s = last_grant_r + 2'd1 + k[1:0];
      if (!rr_found_s && req_valid[cand_s]) begin
        rr_id_s    = cand_s;
        rr_found_s = 1'b1;
      end else begin
        rr_found_s = rr_found_s;
      end
    end
  end

  // A presented-but-unaccepted grant stays locked while its requester keeps asserting valid.
  always_comb begin
    lock_hold_s = lock_r && req_valid[lock_id_r];
    if (lock_hold_s) begin
      grant_id_s = lock_id_r;
    end else begin
      grant_id_s = rr_id_s;
    end
  end

  // Request side handshake; everything is forced idle while reset is asserted.
  always_comb begin
    any_valid_s = |req_valid;
    tag_full_s  = (count_r == CNT_W'(TAG_DEPTH));
    tag_empty_s = (count_r == {CNT_W{1'b0}});
    data        = req_data[32'(grant_id_s) * DATA_W +: DATA_W];
    data_valid  = reset && any_valid_s && !tag_full_s;
    push_s      = data_valid && data_ready;
    if (push_s) begin
      req_ready = id_onehot(grant_id_s);
    end else begin
      req_ready = 4'b0000;
    end
  end

  // Response side routing by the oldest in-flight tag.
  always_comb begin
    head_id_s    = tag_mem_r[rd_ptr_r];
    rsp_result   = result;
    result_ready = reset && !tag_empty_s && rsp_ready[head_id_s];
    pop_s        = result_valid && result_ready;
    busy         = !tag_empty_s;
    err_orphan   = err_orphan_r;
    if (reset && result_valid && !tag_empty_s) begin
      rsp_valid = id_onehot(head_id_s);
    end else begin
      rsp_valid = 4'b0000;
    end
  end

  // Arbitration state: last winner and grant lock.
  always_ff @(posedge clock) begin
    if (!reset) begin
      last_grant_r <= 2'd3;
      lock_r       <= 1'b0;
      lock_id_r    <= 2'd0;
    end else begin
      if (push_s) begin
        last_grant_r <= grant_id_s;
      end
      if (data_valid && !data_ready) begin
        lock_r    <= 1'b1;
        lock_id_r <= grant_id_s;
      end else begin
        lock_r    <= 1'b0;
      end
    end
  end

  // Tag storage; contents are only meaningful below the count, so no reset is needed.
  always_ff @(posedge clock) begin
    if (push_s) begin
      tag_mem_r[wr_ptr_r] <= grant_id_s;
    end
  end

  // Tag FIFO pointers and occupancy.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky flag for a result arriving with nothing in flight.
  always_ff @(posedge clock) begin
    if (!reset) begin
      err_orphan_r <= 1'b0;
    end else if (result_valid && tag_empty_s) begin
      err_orphan_r <= 1'b1;
    end
  end

`ifdef PIPE_ARB_STATS_EN
  logic [3:0][15:0] grant_cnt_r;
  logic [15:0]      stall_cnt_r;

  // Wrapping per-requester acceptance and stall-cycle counters.
  always_ff @(posedge clock) begin
    if (!reset) begin
      grant_cnt_r <= {4{16'd0}};
      stall_cnt_r <= 16'd0;
    end else begin
      if (push_s) begin
        grant_cnt_r[grant_id_s] <= grant_cnt_r[grant_id_s] + 16'd1;
      end
      if (any_valid_s && !push_s) begin
        stall_cnt_r <= stall_cnt_r + 16'd1;
      end
    end
  end

  assign stat_grants = grant_cnt_r;
  assign stat_stall  = stall_cnt_r;
`endif

  pipeline_arbiter_chk #(
    .TAG_DEPTH (TAG_DEPTH),
    .CNT_W     (CNT_W)
  ) u_chk (
    .clock     (clock),
    .reset     (reset),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .push      (push_s),
    .tag_full  (tag_full_s),
    .count     (count_r)
  );

endmodule

// Structural invariants of the arbiter, kept apart from the datapath.
module pipeline_arbiter_chk #(
  parameter int TAG_DEPTH = 8,
  parameter int CNT_W     = 4
) (
  input logic             clock,
  input logic             reset,
  input logic [3:0]       req_ready,
  input logic [3:0]       rsp_valid,
  input logic             push,
  input logic             tag_full,
  input logic [CNT_W-1:0] count
);

  a_req_ready_onehot: assert property (@(posedge clock) disable iff (!reset) $onehot0(req_ready));
  a_rsp_valid_onehot: assert property (@(posedge clock) disable iff (!reset) $onehot0(rsp_valid));
  a_no_push_when_full: assert property (@(posedge clock) disable iff (!reset) !(push && tag_full));
  a_count_in_range: assert property (@(posedge clock) disable iff (!reset) count <= CNT_W'(TAG_DEPTH));

endmodule

// File: tb/tb_pipeline_arbiter.sv
// Scoreboard bench for pipeline_arbiter: directed stimulus pushes expected grants/responses,
// a monitor pops and compares on each handshake. Stats ports are covered when PIPE_ARB_STATS_EN is defined.

module tb_pipeline_arbiter;

  localparam int DATA_W    = 16;
  localparam int TAG_DEPTH = 8;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic [4*DATA_W-1:0] req_data;
  logic [3:0]          req_valid = 4'b0000;
  logic [3:0]          req_ready;
  logic [DATA_W-1:0]   data;
  logic                data_valid;
  logic                data_ready = 1'b0;
  logic [DATA_W-1:0]   result = '0;
  logic                result_valid = 1'b0;
  logic                result_ready;
  logic [DATA_W-1:0]   rsp_result;
  logic [3:0]          rsp_valid;
  logic [3:0]          rsp_ready = 4'b0000;
  logic                busy;
  logic                err_orphan;
`ifdef PIPE_ARB_STATS_EN
  logic [4*16-1:0]     stat_grants;
  logic [15:0]         stat_stall;
`endif

  bit                  res_en = 1'b0;
  bit                  orphan_pulse = 1'b0;
  int                  n_checks = 0;
  int                  n_fail = 0;

  int                  exp_grant_q[$];
  int                  exp_rsp_id_q[$];
  logic [DATA_W-1:0]   exp_rsp_val_q[$];
  logic [DATA_W-1:0]   pipe_q[$];

  pipeline_arbiter #(.DATA_W(DATA_W), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_data     (req_data),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .data         (data),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .rsp_result   (rsp_result),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .busy         (busy),
    .err_orphan   (err_orphan)
`ifdef PIPE_ARB_STATS_EN
    ,
    .stat_grants  (stat_grants),
    .stat_stall   (stat_stall)
`endif
  );

  initial forever #5 clock = ~clock;

  function automatic logic [DATA_W-1:0] lane_val(input int i);
    return 16'h1111 * 16'(i + 1);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_grant(input int id, input bit with_rsp);
    exp_grant_q.push_back(id);
    if (with_rsp) begin
      exp_rsp_id_q.push_back(id);
      exp_rsp_val_q.push_back(lane_val(id) + 16'h0001);
    end
  endtask

  // Pipeline model: one-cycle pass-through returning data+1, plus forced orphan pulses.
  initial forever begin
    @(negedge clock);
    #1;
    if (orphan_pulse) begin
      result_valid = 1'b1;
      result       = 16'hDEAD;
    end else if (res_en && pipe_q.size() > 0) begin
      result_valid = 1'b1;
      result       = pipe_q[0];
    end else begin
      result_valid = 1'b0;
      result       = '0;
    end
  end

  // Monitor: evaluates the handshakes that will complete on the coming rising edge.
  initial begin
    int id;
    logic [DATA_W-1:0] v;
    forever begin
      @(negedge clock);
      #2;
      if (!reset) begin
        pipe_q.delete();
      end else begin
        if (data_valid && data_ready) begin
          if (exp_grant_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_grant: req_ready=%0h data=%0h with no grant expected", req_ready, data);
          end else begin
            id = exp_grant_q.pop_front();
            check("grant_req_ready", 64'(req_ready), 64'(4'b0001 << id));
            check("grant_data", 64'(data), 64'(lane_val(id)));
          end
          pipe_q.push_back(data + 16'h0001);
        end
        if (result_valid && result_ready) begin
          if (pipe_q.size() > 0) void'(pipe_q.pop_front());
          if (exp_rsp_id_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rsp: rsp_valid=%0h rsp_result=%0h with no response expected", rsp_valid, rsp_result);
          end else begin
            id = exp_rsp_id_q.pop_front();
            v  = exp_rsp_val_q.pop_front();
            check("rsp_valid_target", 64'(rsp_valid), 64'(4'b0001 << id));
            check("rsp_result", 64'(rsp_result), 64'(v));
          end
        end
      end
    end
  end

  task automatic wait_drain(input string name);
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (exp_grant_q.size() == 0 && exp_rsp_id_q.size() == 0) break;
    end
    #3;
    check({name, "_grants_drained"}, 64'(exp_grant_q.size()), 64'd0);
    check({name, "_rsps_drained"}, 64'(exp_rsp_id_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset        = 1'b0;
    req_valid    = 4'b0000;
    data_ready   = 1'b0;
    rsp_ready    = 4'b0000;
    res_en       = 1'b0;
    orphan_pulse = 1'b0;
    exp_grant_q.delete();
    exp_rsp_id_q.delete();
    exp_rsp_val_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    req_data = {lane_val(3), lane_val(2), lane_val(1), lane_val(0)};

    // Outputs held idle while reset is low, even with requests pending.
    repeat (2) @(negedge clock);
    req_valid  = 4'hF;
    data_ready = 1'b1;
    rsp_ready  = 4'hF;
    #3;
    check("reset_req_ready", 64'(req_ready), 64'd0);
    check("reset_data_valid", 64'(data_valid), 64'd0);
    check("reset_result_ready", 64'(result_ready), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_err_orphan", 64'(err_orphan), 64'd0);

    // Single requester 2 straight out of reset.
    @(negedge clock);
    reset     = 1'b1;
    req_valid = 4'b0100;
    res_en    = 1'b1;
    expect_grant(2, 1'b1);
    #3;
    check("t1_req_ready", 64'(req_ready), 64'(4'b0100));
    check("t1_data", 64'(data), 64'(lane_val(2)));
    @(negedge clock);
    req_valid = 4'b0000;
    #3;
    check("t1_busy", 64'(busy), 64'd1);
    wait_drain("t1");

    // All four requesting: strict rotation 0,1,2,3,0,1,2,3.
    do_reset();
    for (int i = 0; i < 8; i++) expect_grant(i % 4, 1'b1);
    @(negedge clock);
    req_valid  = 4'hF;
    data_ready = 1'b1;
    rsp_ready  = 4'hF;
    res_en     = 1'b1;
    repeat (7) @(negedge clock);
    @(negedge clock);
    req_valid = 4'b0000;
    wait_drain("t2");
`ifdef PIPE_ARB_STATS_EN
    check("t2_stat_grants", 64'(stat_grants), 64'h0002_0002_0002_0002);
    check("t2_stat_stall", 64'(stat_stall), 64'd0);
`endif

    // Grant lock: requester 1 stalled, requester 0 rises, grant must stay on 1.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      req_valid  = 4'b0010;
      data_ready = 1'b0;
      rsp_ready  = 4'hF;
      res_en     = 1'b1;
      #3;
      check("t3_stall_data_valid", 64'(data_valid), 64'd1);
      check("t3_stall_data", 64'(data), 64'(lane_val(1)));
      check("t3_stall_req_ready", 64'(req_ready), 64'd0);
    end
    @(negedge clock);
    req_valid = 4'b0011;
    #3;
    check("t3_locked_data", 64'(data), 64'(lane_val(1)));
    @(negedge clock);
    data_ready = 1'b1;
    expect_grant(1, 1'b1);
    #3;
    check("t3_accept_req_ready", 64'(req_ready), 64'(4'b0010));
    @(negedge clock);
    expect_grant(0, 1'b1);
    #3;
    check("t3_next_data", 64'(data), 64'(lane_val(0)));
    @(negedge clock);
    req_valid = 4'b0000;
    wait_drain("t3");
`ifdef PIPE_ARB_STATS_EN
    check("t3_stat_stall", 64'(stat_stall), 64'd4);
`endif

    // Fill the tag FIFO with responses blocked, then free exactly one slot.
    do_reset();
    for (int i = 0; i < 8; i++) expect_grant(0, 1'b1);
    @(negedge clock);
    req_valid  = 4'b0001;
    data_ready = 1'b1;
    rsp_ready  = 4'b0000;
    res_en     = 1'b1;
    repeat (7) @(negedge clock);
    @(negedge clock);
    #3;
    check("t4_full_data_valid", 64'(data_valid), 64'd0);
    check("t4_full_req_ready", 64'(req_ready), 64'd0);
    check("t4_full_result_ready", 64'(result_ready), 64'd0);
    @(negedge clock);
    rsp_ready = 4'b0001;
    #3;
    check("t4_pop_cycle_data_valid", 64'(data_valid), 64'd0);
    check("t4_pop_cycle_result_ready", 64'(result_ready), 64'd1);
    @(negedge clock);
    rsp_ready = 4'b0000;
    expect_grant(0, 1'b1);
    #3;
    check("t4_refill_data_valid", 64'(data_valid), 64'd1);
    check("t4_refill_req_ready", 64'(req_ready), 64'(4'b0001));
    @(negedge clock);
    #3;
    check("t4_refull_data_valid", 64'(data_valid), 64'd0);
    @(negedge clock);
    req_valid = 4'b0000;
    rsp_ready = 4'hF;
    wait_drain("t4");

    // Orphan result with nothing in flight.
    do_reset();
    @(negedge clock);
    rsp_ready    = 4'hF;
    orphan_pulse = 1'b1;
    #3;
    check("t5_orphan_result_ready", 64'(result_ready), 64'd0);
    check("t5_orphan_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clock);
    orphan_pulse = 1'b0;
    #3;
    check("t5_err_orphan_set", 64'(err_orphan), 64'd1);
    check("t5_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clock);
    #3;
    check("t5_err_orphan_sticky", 64'(err_orphan), 64'd1);

    // Mid-operation reset with five tags in flight.
    do_reset();
    #3;
    check("t6_err_orphan_cleared", 64'(err_orphan), 64'd0);
    expect_grant(0, 1'b0);
    expect_grant(1, 1'b0);
    expect_grant(2, 1'b0);
    expect_grant(3, 1'b0);
    expect_grant(0, 1'b0);
    @(negedge clock);
    req_valid  = 4'hF;
    data_ready = 1'b1;
    rsp_ready  = 4'b0000;
    res_en     = 1'b1;
    repeat (4) @(negedge clock);
    @(negedge clock);
    req_valid = 4'b0000;
    #3;
    check("t6_busy_in_flight", 64'(busy), 64'd1);
    @(negedge clock);
    reset     = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 4'hF;
    #3;
    check("t6_rst_data_valid", 64'(data_valid), 64'd0);
    check("t6_rst_req_ready", 64'(req_ready), 64'd0);
    check("t6_rst_result_ready", 64'(result_ready), 64'd0);
    check("t6_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clock);
    #3;
    check("t6_busy_after_reset", 64'(busy), 64'd0);
`ifdef PIPE_ARB_STATS_EN
    check("t6_stat_grants_cleared", 64'(stat_grants), 64'd0);
    check("t6_stat_stall_cleared", 64'(stat_stall), 64'd0);
`endif
    @(negedge clock);
    req_valid = 4'b0000;
    reset     = 1'b1;
    check("final_grants_consumed", 64'(exp_grant_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d comparisons made, %0d failed", n_checks, n_fail);
    $fatal(1);
  end

endmodule
